// File: rtl/wb_burst_reader_pkg.sv
// Shared types and constants for the Wishbone burst reader.
// Imported by the FIFO and the top-level master.
package wb_burst_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPACE,
    REQ,
    GAP,
    FINISH
  } state_e;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wb_burst_reader_fifo.sv
// First-word-fall-through FIFO between the bus side and the stream side.
// Head word is visible in the same cycle the FIFO becomes non-empty.
module wb_burst_reader_fifo
  import wb_burst_reader_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic [DATA_W-1:0]       head_data,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_q;
  logic [AW-1:0]     rp_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              pop_ok;

  assign pop_ok = pop && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push)   wp_q <= wp_q + 1'b1;
      if (pop_ok) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only visible behind cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= push_data;
  end

  assign head_data = mem_q[rp_q];
  assign count     = cnt_q;
  assign empty     = (cnt_q == '0);

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone classic read master: fetches LEN words from BRAM into a FIFO
// and streams them out over valid/ready.
module wb_burst_reader
  import wb_burst_reader_pkg::*;
#(
  parameter int ADR_W      = 11,
  parameter int LEN_W      = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADR_W-1:0]  base_adr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [SEL_W-1:0]  wb_sel,
  output logic [ADR_W-1:0]  wb_adr,
  output logic [DATA_W-1:0] wb_dat_ms,
  input  logic [DATA_W-1:0] wb_dat_sm,
  input  logic              wb_ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  state_e            state_q;
  logic [ADR_W-1:0]  adr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              cyc_q;
  logic              busy_q;
  logic              done_q;

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic [CW-1:0]     fcount;
  logic              fempty;

  assign push = (state_q == REQ) && wb_ack;
  assign pop  = !fempty && out_ready;

  wb_burst_reader_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wb_dat_sm),
    .pop       (pop),
    .head_data (head),
    .count     (fcount),
    .empty     (fempty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (len != '0) begin
              adr_q   <= base_adr;
              rem_q   <= len;
              state_q <= WAIT_SPACE;
            end else begin
              // Empty transfer still shows busy for one cycle.
              rem_q   <= '0;
              state_q <= GAP;
            end
          end
        end
        WAIT_SPACE: begin
          if (fcount < DEPTH_C) begin
            cyc_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (wb_ack) begin
            cyc_q   <= 1'b0;
            adr_q   <= adr_q + 1'b1;
            rem_q   <= rem_q - 1'b1;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (rem_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else begin
            state_q <= WAIT_SPACE;
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wb_cyc    = cyc_q;
  assign wb_stb    = cyc_q;
  assign wb_we     = 1'b0;
  assign wb_sel    = {SEL_W{1'b1}};
  assign wb_adr    = adr_q;
  assign wb_dat_ms = '0;
  assign out_valid = !fempty;
  assign out_data  = fempty ? '0 : head;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Bench for wb_burst_reader: BRAM slave model, queue-based reference
// model with a per-cycle compare process, and directed scenarios.
module tb_wb_burst_reader;

  localparam int ADR_W = 11;
  localparam int LEN_W = 12;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [ADR_W-1:0] base_adr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done;
  logic             wb_cyc, wb_stb, wb_we;
  logic [3:0]       wb_sel;
  logic [ADR_W-1:0] wb_adr;
  logic [31:0]      wb_dat_ms;
  logic [31:0]      wb_dat_sm;
  logic             wb_ack;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int nacks  = 0;
  int ndone  = 0;
  int lat    = 1;

  logic [31:0]      mem [2**ADR_W];
  logic [31:0]      mq[$];
  logic [ADR_W-1:0] exp_adr[$];
  logic [31:0]      got_data[$];
  logic [ADR_W-1:0] got_adr[$];
  logic             prev_done = 1'b0;

  always #5 clk = ~clk;

  wb_burst_reader #(
    .ADR_W      (ADR_W),
    .LEN_W      (LEN_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_adr  (base_adr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_sel    (wb_sel),
    .wb_adr    (wb_adr),
    .wb_dat_ms (wb_dat_ms),
    .wb_dat_sm (wb_dat_sm),
    .wb_ack    (wb_ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // BRAM slave: ack after lat extra cycles, single-cycle ack pulse.
  int s_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack    <= 1'b0;
      wb_dat_sm <= '0;
      s_cnt     <= 0;
    end else if (wb_cyc && wb_stb && !wb_ack) begin
      if (s_cnt >= lat) begin
        wb_ack    <= 1'b1;
        wb_dat_sm <= mem[wb_adr];
        s_cnt     <= 0;
      end else begin
        s_cnt <= s_cnt + 1;
      end
    end else begin
      wb_ack <= 1'b0;
      s_cnt  <= 0;
    end
  end

  // Reference model: expected address list and expected FIFO contents.
  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
      exp_adr.delete();
      prev_done = 1'b0;
      chk("rst_outs",
          {26'd0, busy, done, wb_cyc, wb_stb, out_valid, |out_data},
          32'd0);
      chk("rst_adr", 32'(wb_adr), 32'd0);
    end else begin
      chk("consts", {wb_we, wb_sel, |wb_dat_ms}, {1'b0, 4'hf, 1'b0});
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("out_data", out_data, mq[0]);
      if (wb_cyc) begin
        chk("req_expected", 32'(exp_adr.size() != 0), 32'd1);
        if (exp_adr.size() != 0) chk("wb_adr", 32'(wb_adr), 32'(exp_adr[0]));
        chk("stb_with_cyc", 32'(wb_stb), 32'd1);
        chk("busy_in_req", 32'(busy), 32'd1);
        chk("fifo_space", 32'(mq.size() < DEPTH), 32'd1);
      end
      if (done) begin
        chk("done_single", 32'(prev_done), 32'd0);
        chk("done_all_read", 32'(exp_adr.size()), 32'd0);
        chk("done_not_busy", 32'(busy), 32'd0);
        ndone++;
      end
      prev_done = done;
      if (out_valid && out_ready && mq.size() != 0) begin
        got_data.push_back(out_data);
        void'(mq.pop_front());
      end
      if (wb_cyc && wb_ack && exp_adr.size() != 0) begin
        got_adr.push_back(wb_adr);
        mq.push_back(mem[exp_adr.pop_front()]);
        nacks++;
      end
    end
  end

  task automatic cmd(input logic [ADR_W-1:0] b, input logic [LEN_W-1:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_adr = b; len = l;
    for (int i = 0; i < int'(l); i++) exp_adr.push_back(b + ADR_W'(i));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  task automatic clear_logs();
    got_data.delete();
    got_adr.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int d0, b1;
    int ncyc;
    bit seen;
    logic [31:0] e5 [5];
    logic [31:0] ew [4];
    e5 = '{32'h20, 32'h21, 32'h22, 32'h40, 32'h41};
    ew = '{32'h7fe, 32'h7ff, 32'h0, 32'h1};
    for (int k = 0; k < 2**ADR_W; k++) mem[k] = 32'(k);

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Basic 4-word burst, always-ready consumer.
    lat = 1; out_ready = 1'b1; clear_logs(); d0 = ndone;
    cmd(11'h010, 12'd4);
    wait_done("t2_done", 200);
    repeat (4) @(posedge clk);
    chk("t2_ndata", 32'(got_data.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      chk("t2_data", got_data[i], 32'h10 + 32'(i));
      chk("t2_adr", 32'(got_adr[i]), 32'h10 + 32'(i));
    end
    chk("t2_ndone", 32'(ndone - d0), 32'd1);

    // Zero length: busy one cycle, done two cycles after start.
    @(posedge clk); #1;
    start = 1'b1; len = '0; base_adr = 11'h055;
    ncyc = 0;
    @(negedge clk);
    chk("t3_c0", {busy, done, wb_cyc}, 32'b000);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("t3_c1", {busy, done, wb_cyc}, 32'b100);
    @(negedge clk);
    chk("t3_c2", {busy, done, wb_cyc}, 32'b010);
    @(negedge clk);
    chk("t3_c3", {busy, done, wb_cyc}, 32'b000);

    // Back-pressure: FIFO fills after 8 reads, then stalls.
    lat = 0; out_ready = 1'b0; clear_logs(); b1 = nacks;
    cmd(11'h100, 12'd12);
    for (int i = 0; i < 300 && (nacks - b1) < DEPTH; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("t4_acks_full", 32'(nacks - b1), 32'd8);
    chk("t4_stall", {wb_cyc, busy, out_valid}, 32'b011);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done("t4_done", 400);
    repeat (4) @(posedge clk);
    chk("t4_ndata", 32'(got_data.size()), 32'd12);
    for (int i = 0; i < got_data.size(); i++)
      chk("t4_data", got_data[i], 32'h100 + 32'(i));

    // Address wrap at top of memory.
    lat = 2; clear_logs();
    cmd(11'h7fe, 12'd4);
    wait_done("t5_done", 200);
    repeat (4) @(posedge clk);
    chk("t5_nadr", 32'(got_adr.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_adr.size(); i++) begin
      chk("t5_adr", 32'(got_adr[i]), ew[i]);
      chk("t5_data", got_data[i], ew[i]);
    end

    // Starts while busy and in FINISH are ignored; the next is taken.
    lat = 0; out_ready = 1'b0; clear_logs();
    cmd(11'h020, 12'd3);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wb_cyc) begin seen = 1'b1; break; end
    end
    chk("t6_req_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    start = 1'b1; base_adr = 11'h300; len = 12'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t6_done1", 200);
    start = 1'b1; base_adr = 11'h300; len = 12'd2;
    @(posedge clk); #1;
    base_adr = 11'h040;
    exp_adr.push_back(11'h040);
    exp_adr.push_back(11'h041);
    @(posedge clk); #1 start = 1'b0;
    chk("t6_fifo_nonempty", 32'(out_valid), 32'd1);
    wait_done("t6_done2", 200);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (8) @(posedge clk);
    chk("t6_ndata", 32'(got_data.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_data.size(); i++)
      chk("t6_data", got_data[i], e5[i]);

    // Asynchronous reset in the middle of a request.
    lat = 3; out_ready = 1'b1;
    cmd(11'h000, 12'd4);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wb_cyc) begin seen = 1'b1; break; end
    end
    chk("t1_req_seen", 32'(seen), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("t1_rst_now", {wb_cyc, wb_stb, out_valid, busy}, 32'b0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wb_cyc || busy) ncyc++;
    end
    chk("t1_idle_after", 32'(ncyc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
